// File: rtl/spike_gen_rate_enc_if.sv
// Load/start port of the value store plus the AER event valid/ready channel of spike_gen_rate_enc.
`timescale 1ns/1ps
interface spike_gen_rate_enc_if #(
    parameter int N_INPUTS = 1023,
    parameter int DATA_W   = 8
);
    localparam int AW = $clog2(N_INPUTS);

    logic [AW-1:0]     LOAD_input_value_ADDR;
    logic              LOAD_input_en;
    logic [DATA_W-1:0] Pre_processed_dat;
    logic              pre_processing_done;
    logic              spike_ready;
    logic              spike_out;
    logic [AW-1:0]     spike_AER;
    logic              current_step_finished;
    logic              all_steps_done;
    logic              busy;

    modport master (
        output LOAD_input_value_ADDR, LOAD_input_en, Pre_processed_dat,
               pre_processing_done, spike_ready,
        input  spike_out, spike_AER, current_step_finished, all_steps_done, busy
    );

    modport slave (
        input  LOAD_input_value_ADDR, LOAD_input_en, Pre_processed_dat,
               pre_processing_done, spike_ready,
        output spike_out, spike_AER, current_step_finished, all_steps_done, busy
    );
endinterface

// File: rtl/spike_gen_rate_enc.sv
// Rate-encoding spike generator: integrates stored values over NUM_STEPS steps, emits AER events.
// Define SPKGEN_RESIDUE_EN to keep the above-threshold residue on fire instead of resetting to zero.
`timescale 1ns/1ps
module spike_gen_rate_enc #(
    parameter int N_INPUTS  = 1023,
    parameter int DATA_W    = 8,
    parameter int NUM_STEPS = 8,
    parameter int THRESH    = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    spike_gen_rate_enc_if.slave bus
);
    localparam int AW    = $clog2(N_INPUTS);
    localparam int ACC_W = DATA_W + 1;
    localparam int SW    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    localparam logic [AW-1:0]    LAST_IDX  = AW'(N_INPUTS - 1);
    localparam logic [SW-1:0]    LAST_STEP = SW'(NUM_STEPS - 1);
    localparam logic [ACC_W-1:0] THRESH_C  = ACC_W'(THRESH);
    localparam logic [AW:0]      N_C       = (AW + 1)'(N_INPUTS);

    typedef enum logic [2:0] {IDLE, SCAN, EMIT, STEP_END, DONE} state_t;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [SW-1:0]     step;
    logic              spike_out_q;
    logic [AW-1:0]     spike_aer_q;
    logic              step_fin_q;
    logic              all_done_q;
    logic              busy_q;

    logic [DATA_W-1:0] value_mem [N_INPUTS];
    logic [ACC_W-1:0]  acc_mem   [N_INPUTS];

    logic [ACC_W-1:0]  acc_cur;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_wdata;
    logic              fire;
    logic              value_we;
    logic              acc_we;

    // Step 0 reads the accumulator as zero, so no clearing pass is needed between runs.
    always_comb begin
        acc_cur  = (step == '0) ? '0 : acc_mem[idx];
        sum      = acc_cur + ACC_W'(value_mem[idx]);
        fire     = (sum >= THRESH_C);
`ifdef SPKGEN_RESIDUE_EN
        acc_wdata = fire ? (sum - THRESH_C) : sum;
`else
        acc_wdata = fire ? '0 : sum;
`endif
        acc_we   = (state == SCAN);
        value_we = (state == IDLE) && bus.LOAD_input_en
                   && ({1'b0, bus.LOAD_input_value_ADDR} < N_C);
    end

    // Stores carry no reset; contents are meaningless until reloaded.
    always_ff @(posedge clk) begin
        if (value_we)
            value_mem[bus.LOAD_input_value_ADDR] <= bus.Pre_processed_dat;
        if (acc_we)
            acc_mem[idx] <= acc_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            step        <= '0;
            spike_out_q <= 1'b0;
            spike_aer_q <= '0;
            step_fin_q  <= 1'b0;
            all_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pre_processing_done) begin
                        state  <= SCAN;
                        idx    <= '0;
                        step   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (fire) begin
                        spike_aer_q <= idx;
                        spike_out_q <= 1'b1;
                        state       <= EMIT;
                    end else if (idx == LAST_IDX) begin
                        step_fin_q <= 1'b1;
                        state      <= STEP_END;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.spike_ready) begin
                        spike_out_q <= 1'b0;
                        if (idx == LAST_IDX) begin
                            step_fin_q <= 1'b1;
                            state      <= STEP_END;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                STEP_END: begin
                    step_fin_q <= 1'b0;
                    if (step == LAST_STEP) begin
                        all_done_q <= 1'b1;
                        state      <= DONE;
                    end else begin
                        step  <= step + 1'b1;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                DONE: begin
                    all_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.spike_out             = spike_out_q;
    assign bus.spike_AER             = spike_aer_q;
    assign bus.current_step_finished = step_fin_q;
    assign bus.all_steps_done        = all_done_q;
    assign bus.busy                  = busy_q;
endmodule

// File: tb/tb_spike_gen_rate_enc.sv
// Directed table-driven bench for spike_gen_rate_enc (N_INPUTS=4, DATA_W=8, THRESH=256, NUM_STEPS=8).
`timescale 1ns/1ps
module tb_spike_gen_rate_enc;
    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int NS     = 8;
    localparam int TH     = 256;
    localparam int AWL    = 2;
    localparam int BUDGET = 2000;
    localparam int NVEC   = 7;

    // Expected fire masks: nibble s holds the inputs firing in step s (0-based), bit i = input i.
`ifdef SPKGEN_RESIDUE_EN
    localparam logic [31:0] M_S1  = 32'hDCDCCDC0;
    localparam logic [31:0] M_RES = 32'h10100100;
    localparam logic [31:0] M_BP  = 32'h55555550;
    localparam logic [31:0] M_MIX = 32'h32B03A30;
`else
    localparam logic [31:0] M_S1  = 32'hC0D0C1C0;
    localparam logic [31:0] M_RES = 32'h00100100;
    localparam logic [31:0] M_BP  = 32'h50505050;
    localparam logic [31:0] M_MIX = 32'h30B03830;
`endif

    typedef struct packed {
        logic [31:0] vals;   // {v3, v2, v1, v0}
        logic [31:0] masks;
        logic [3:0]  stall;
        logic        reload;
        logic        inject;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    spike_gen_rate_enc_if #(.N_INPUTS(N), .DATA_W(DW)) bus ();

    spike_gen_rate_enc #(
        .N_INPUTS (N),
        .DATA_W   (DW),
        .NUM_STEPS(NS),
        .THRESH   (TH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] outs_packed();
        return 32'({bus.spike_out, bus.spike_AER, bus.current_step_finished,
                    bus.all_steps_done, bus.busy});
    endfunction

    task automatic load_vals(input logic [31:0] vals);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.LOAD_input_en         = 1'b1;
            bus.LOAD_input_value_ADDR = AWL'(i);
            bus.Pre_processed_dat     = vals[8*i +: 8];
        end
        @(negedge clk);
        bus.LOAD_input_en = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [3:0]     seen = '0;
        logic [AWL-1:0] held = '0;
        int step = 0, step_cyc = 0, run_cyc = 0, exp_run = 0;
        int k = 0, last_idx = -1, pop, stable_bad = 0, busy_bad = 0;
        bit in_ev = 1'b0, done = 1'b0;
        @(negedge clk);
        bus.pre_processing_done = 1'b1;
        @(negedge clk);
        bus.pre_processing_done = 1'b0;
        bus.spike_ready = (v.stall == 0);
        while (!done && run_cyc < BUDGET) begin
            run_cyc++;
            step_cyc++;
            if (bus.busy !== 1'b1) busy_bad++;
            if (v.inject && run_cyc == 3) begin
                bus.LOAD_input_en         = 1'b1;
                bus.LOAD_input_value_ADDR = AWL'(1);
                bus.Pre_processed_dat     = 8'd255;
                bus.pre_processing_done   = 1'b1;
            end else begin
                bus.LOAD_input_en       = 1'b0;
                bus.pre_processing_done = 1'b0;
            end
            if (bus.spike_out) begin
                if (!in_ev) begin
                    in_ev = 1'b1;
                    k     = 0;
                    held  = bus.spike_AER;
                    check($sformatf("v%0d_s%0d_order", id, step), 32'(int'(held) > last_idx), 32'd1);
                    check($sformatf("v%0d_s%0d_dup", id, step), 32'(seen[held]), 32'd0);
                    seen[held] = 1'b1;
                    last_idx   = int'(held);
                end else if (bus.spike_AER !== held) begin
                    stable_bad++;
                end
                bus.spike_ready = (k >= int'(v.stall));
                if (k >= int'(v.stall)) in_ev = 1'b0;
                k++;
            end else begin
                if (in_ev) begin
                    stable_bad++;
                    in_ev = 1'b0;
                end
                bus.spike_ready = (v.stall == 0);
            end
            if (bus.current_step_finished) begin
                if (step < NS) begin
                    pop = $countones(v.masks[4*step +: 4]);
                    check($sformatf("v%0d_s%0d_mask", id, step), 32'(seen), 32'(v.masks[4*step +: 4]));
                    check($sformatf("v%0d_s%0d_len", id, step), 32'(step_cyc),
                          32'(N + pop * (1 + int'(v.stall)) + 1));
                    exp_run += N + pop * (1 + int'(v.stall)) + 1;
                end
                step++;
                step_cyc = 0;
                seen     = '0;
                last_idx = -1;
            end
            if (bus.all_steps_done) begin
                check($sformatf("v%0d_steps", id), 32'(step), 32'(NS));
                check($sformatf("v%0d_runlen", id), 32'(run_cyc), 32'(exp_run + 1));
                done = 1'b1;
            end
            @(negedge clk);
        end
        check($sformatf("v%0d_timeout", id), 32'(done), 32'd1);
        check($sformatf("v%0d_stable", id), 32'(stable_bad), 32'd0);
        check($sformatf("v%0d_busy_run", id), 32'(busy_bad), 32'd0);
        check($sformatf("v%0d_busy_after", id), 32'(bus.busy), 32'd0);
        bus.spike_ready         = 1'b1;
        bus.LOAD_input_en       = 1'b0;
        bus.pre_processing_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{vals: 32'hFFFF0064, masks: M_S1,  stall: 4'd0, reload: 1'b1, inject: 1'b0};
        vecs[1] = '{vals: 32'h00000064, masks: M_RES, stall: 4'd0, reload: 1'b1, inject: 1'b0};
        vecs[2] = '{vals: 32'h00FF00FF, masks: M_BP,  stall: 4'd5, reload: 1'b1, inject: 1'b0};
        vecs[3] = '{vals: 32'hFFFF0064, masks: M_S1,  stall: 4'd0, reload: 1'b1, inject: 1'b1};
        vecs[4] = '{vals: 32'h00000000, masks: M_S1,  stall: 4'd0, reload: 1'b0, inject: 1'b0};
        vecs[5] = '{vals: 32'h5601C880, masks: M_MIX, stall: 4'd0, reload: 1'b1, inject: 1'b0};
        vecs[6] = '{vals: 32'h00000000, masks: 32'h0, stall: 4'd0, reload: 1'b1, inject: 1'b0};

        rst_n                     = 1'b0;
        bus.LOAD_input_value_ADDR = '0;
        bus.LOAD_input_en         = 1'b0;
        bus.Pre_processed_dat     = '0;
        bus.pre_processing_done   = 1'b0;
        bus.spike_ready           = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs_packed(), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].reload) load_vals(vecs[i].vals);
            run_vec(i, vecs[i]);
        end

        // Reset while an event is stalled in EMIT.
        begin
            int w = 0;
            load_vals(vecs[0].vals);
            bus.spike_ready = 1'b0;
            @(negedge clk);
            bus.pre_processing_done = 1'b1;
            @(negedge clk);
            bus.pre_processing_done = 1'b0;
            while (!bus.spike_out && w < 200) begin
                @(negedge clk);
                w++;
            end
            check("midemit_reached", 32'(bus.spike_out), 32'd1);
            rst_n = 1'b0;
            #1;
            check("midemit_reset_outputs", outs_packed(), 32'd0);
            @(negedge clk);
            check("midemit_reset_held", outs_packed(), 32'd0);
            rst_n = 1'b1;
            bus.spike_ready = 1'b1;
            load_vals(vecs[0].vals);
            run_vec(10, vecs[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spike_gen_rate_enc.md
# spike_gen_rate_enc

Parametrised rate-encoding spike generator. It replaces the fixed-size spike generation top with configurable input count, value width, step count and threshold. Pre-processed input values are loaded into an internal value store. On `pre_processing_done`, the block runs `NUM_STEPS` time steps. In each step it integrates every input into a per-input accumulator and emits an AER event for each input that crosses threshold. Events are offered downstream over a valid/ready handshake, so the SNN core can backpressure.

## Interface
- `N_INPUTS`, 1023: number of input channels. Must be ≥ 2.
- `DATA_W`, 8: width of a pre-processed value.
- `NUM_STEPS`, 8: time steps per run. Must be ≥ 1.
- `THRESH`, 256: firing threshold. Range 1..2^DATA_W.
- Derived, not overridable:
  - `AW` = $clog2(N_INPUTS).
  - `ACC_W` = DATA_W+1.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `LOAD_input_value_ADDR` in AW: write address into the value store.
- `LOAD_input_en` in 1: write strobe for the value store.
- `Pre_processed_dat` in DATA_W: write data for the value store.
- `pre_processing_done` in 1: start pulse.
- `spike_ready` in 1: downstream accepts the event.
- `spike_out` out 1: event valid.
- `spike_AER` out AW: index of the spiking input.
- `current_step_finished` out 1: one-cycle pulse at the end of each step.
- `all_steps_done` out 1: one-cycle pulse at the end of a run.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Storage:
  - Value store: N_INPUTS×DATA_W.
  - Accumulator store: N_INPUTS×ACC_W.
  - Both stores have combinational read and synchronous write.
- The block has five states: IDLE, SCAN, EMIT, STEP_END, DONE.
- **IDLE**
  - A write occurs when `LOAD_input_en`=1: `value[ADDR] <= Pre_processed_dat`.
  - Writes with ADDR ≥ N_INPUTS are ignored.
  - `pre_processing_done`=1 moves to SCAN with idx=0 and step=0.
  - If a load and a start arrive in the same cycle, the load is performed and the run uses the newly written value.
- **SCAN** evaluates one input per cycle:
  - a = (step==0) ? 0 : acc[idx]. This means no separate clearing pass is needed.
  - s = a + value[idx], computed in ACC_W bits so it never overflows.
  - If s ≥ THRESH, the input fires. The accumulator update is `acc[idx] <= 0`, or see Configuration. The block registers `spike_AER`=idx and `spike_out`=1, then moves to EMIT.
  - If s < THRESH, `acc[idx] <= s`. If idx==N_INPUTS-1 the block moves to STEP_END, otherwise idx++.
- **EMIT**
  - `spike_out` and `spike_AER` are held stable until `spike_ready`=1.
  - On that handshake cycle the block clears `spike_out`. It then goes to STEP_END if idx==N_INPUTS-1, otherwise it does idx++ and returns to SCAN.
- **STEP_END**
  - `current_step_finished`=1 for exactly this one cycle.
  - If step==NUM_STEPS-1 the block goes to DONE. Otherwise it does step++ and idx=0, and returns to SCAN.
- **DONE**
  - `all_steps_done`=1 for one cycle, then IDLE.
  - The value store is retained, so a new start repeats the run without reloading.
- Loads and starts are ignored whenever `busy`=1.
- `spike_ready` is ignored outside EMIT.
- Reset, either at power-up or mid-run:
  - The block goes straight to IDLE and clears idx and step.
  - All outputs are 0: `spike_out`, `spike_AER`, `current_step_finished`, `all_steps_done`, `busy`.
  - Store contents are undefined after reset. The bench must reload before starting.

## Timing
- Start sampled at edge t → `busy`=1 and idx 0 is evaluated in the cycle after t.
- Non-firing input: 1 cycle.
- Firing input:
  - `spike_out` is high from the cycle after evaluation.
  - It falls on the edge after the first cycle with `spike_ready`=1.
  - With `spike_ready` tied high, a firing input costs 2 cycles.
- Step cost: N_INPUTS + (number of spikes) + wait cycles + 1 for STEP_END.
- Run cost: sum of the step costs + 1 for DONE.
- At most one event is outstanding. Events are emitted in ascending index order within a step.
- `current_step_finished` of step k precedes every event of step k+1.

## Configuration
- `SPKGEN_RESIDUE_EN` defined: on fire, `acc[idx] <= s - THRESH`. The residue is kept, so the long-run spike rate equals value/THRESH.
- `SPKGEN_RESIDUE_EN` undefined: on fire, `acc[idx] <= 0` (reset-to-zero).

## Test plan
All scenarios use N_INPUTS=4, DATA_W=8, THRESH=256, NUM_STEPS=8, and `spike_ready`=1 unless stated.
- **Reset-to-zero pattern.**
  - Stimulus: macro off; load values {100, 0, 255, 256-clipped-to-255}; start.
  - Required: input 0 spikes in steps 3 and 6 (1-based); input 1 never spikes; inputs 2 and 3 spike every 2nd step.
  - Required: 8 `current_step_finished` pulses, then one `all_steps_done`.
- **Residue pattern.**
  - Stimulus: macro on; value 100 on input 0; others 0.
  - Required: spikes in steps 3, 6 and 8 only. The accumulator reaches 300→44, 344→88, 288→32.
- **Backpressure.**
  - Stimulus: input 0 = 255, input 2 = 255; hold `spike_ready`=0 for 5 cycles on each event.
  - Required: `spike_AER` stays stable through each stall; events appear as 0, then 2.
  - Required: step length is 4+2+10+1 cycles; no event is lost or duplicated.
- **Ignored commands while busy.**
  - Stimulus: during a run, pulse `pre_processing_done` and write value 255 to address 1.
  - Required: the run is unaffected; value[1] keeps its old value, which a later run confirms.
- **Reset mid-EMIT.**
  - Stimulus: assert `rst_n`=0 while `spike_out`=1.
  - Required: all outputs are 0 immediately; `busy`=0.
  - Required: after reloading and restarting, the step-1 output matches scenario 1.
- **Timing of an all-zero run.**
  - Stimulus: all values 0; start.
  - Required: no `spike_out`; `current_step_finished` every 5 cycles; `all_steps_done` 41 cycles after start.
